lc3_debug_display: RTL and testbench

Debug-display back end of the LC-3 board build: consumes the 16-bit value of the architectural register picked by its own selector and drives the 4-digit multiplexed seven-segment display plus the 4 status LEDs. It also owns the front-panel button. It debounces the button and steps the selector through R0–R7, PC, MAR, MDR, IR. The selector goes back to the core's register-view mux, which returns the corresponding value one cycle later.

---
 rtl/lc3_debug_display.sv | 244 ++++++++++++++++++++++++
 tb/tb_lc3_debug_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_debug_display.sv
// -----------------------------------------------------------------------------
// lc3_debug_display
//
// Debug-display back end for the LC-3 board build. This block owns the
// front-panel button and steps a source selector through R0-R7, PC, MAR, MDR
// and IR. The core's register-view mux takes that selector and returns the
// value of the chosen source. This block shows that value as four hex digits
// on a multiplexed seven-segment display. The status LEDs mirror the selector.
//
// Parameters:
//   SCAN_DIV         clk_0 cycles per displayed digit (>= 2)
//   DEBOUNCE_CYCLES  cycles of stable synchronized high needed to accept a press (>= 1)
//   NUM_SRC          number of selectable sources, codes 0..NUM_SRC-1
//
// Ports:
//   clk_0                in   sole clock
//   rst                  in   asynchronous, active-low reset
//   btn                  in   raw asynchronous button, high = pressed
//   view_value[15:0]     in   value of source view_sel; valid one cycle after view_sel changes
//   view_sel[3:0]        out  source code: 0-7 R0-R7, 8 PC, 9 MAR, 10 MDR, 11 IR
//   seg_output_single    out  active-low segments {dp,g,f,e,d,c,b,a}
//   seg_output_sequence  out  active-low digit enables, bit 0 = least-significant digit
//   led_output[3:0]      out  copy of view_sel
// -----------------------------------------------------------------------------
module lc3_debug_display #(
    parameter int SCAN_DIV        = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_SRC         = 12
) (
    input  logic        clk_0,
    input  logic        rst,
    input  logic        btn,
    input  logic [15:0] view_value,
    output logic [3:0]  view_sel,
    output logic [7:0]  seg_output_single,
    output logic [3:0]  seg_output_sequence,
    output logic [3:0]  led_output
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]       SRC_LAST = 4'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    // Hex digit to active-low segments. The dp bit is left off (1) here.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Button path: synchronizer, saturating stable counter, edge detect
    // ------------------------------------------------------------------
    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_stable_cnt;
    logic            r_btn_d_q;
    logic            w_btn_s;
    logic            w_btn_d;
    logic            w_step;

    assign w_btn_s = r_sync[1];
    assign w_btn_d = (r_stable_cnt == DB_MAX);
    // The step is taken on the rising edge of the debounced level only, so
    // a held button steps once and the release never steps.
    assign w_step  = w_btn_d & ~r_btn_d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values. Asynchronous reset goes in the sensitivity list.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_sync       <= 2'b00;
            r_stable_cnt <= '0;
            r_btn_d_q    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn};
            r_btn_d_q <= w_btn_d;
            if (!w_btn_s)
                r_stable_cnt <= '0;
            else if (r_stable_cnt != DB_MAX)
                r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Selector and step-delay pipe for the snapshot reload
    // ------------------------------------------------------------------
    logic [3:0] r_view_sel;
    logic [3:0] w_view_sel_next;
    logic [1:0] r_step_dly;

    always_comb begin
        w_view_sel_next = r_view_sel;
        if (w_step)
            w_view_sel_next = (r_view_sel == SRC_LAST) ? 4'd0 : r_view_sel + 4'd1;
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_view_sel <= 4'd0;
            r_step_dly <= 2'b00;
        end else begin
            r_view_sel <= w_view_sel_next;
            r_step_dly <= {r_step_dly[0], w_step};
        end
    end

    // ------------------------------------------------------------------
    // Scan divider and digit FSM
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    digit_e           r_state;
    digit_e           w_state_next;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst)
            r_div <= '0;
        else
            r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst)
            r_state <= DIG3;
        else
            r_state <= w_state_next;
    end

    // NOTE: every signal driven in an always_comb gets a default assignment
    // first. This keeps the logic combinational and prevents latches.
    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                DIG0: w_state_next = DIG1;
                DIG1: w_state_next = DIG2;
                DIG2: w_state_next = DIG3;
                DIG3: w_state_next = DIG0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Snapshot: reload on every digit-0 entry and two cycles after a step
    // ------------------------------------------------------------------
    logic [15:0] r_snap;
    logic [15:0] w_snap_next;
    logic        w_enter_dig0;

    assign w_enter_dig0 = w_tick && (r_state == DIG3);
    assign w_snap_next  = (w_enter_dig0 || r_step_dly[1]) ? view_value : r_snap;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst)
            r_snap <= 16'h0000;
        else
            r_snap <= w_snap_next;
    end

    // ------------------------------------------------------------------
    // Registered display outputs. Each output is computed from the next
    // state, snapshot and selector. This way digit enable and segment data
    // change on the same edge as the FSM. The display stays blank until the
    // first scan transition after reset.
    // ------------------------------------------------------------------
    logic       r_blank;
    logic       w_blank_next;
    logic [3:0] w_nibble;
    logic [7:0] w_seg_next;
    logic [3:0] w_seq_next;
    logic [7:0] r_seg;
    logic [3:0] r_seq;

    assign w_blank_next = r_blank & ~w_tick;

    always_comb begin
        w_nibble = w_snap_next[3:0];
        case (w_state_next)
            DIG0: w_nibble = w_snap_next[3:0];
            DIG1: w_nibble = w_snap_next[7:4];
            DIG2: w_nibble = w_snap_next[11:8];
            DIG3: w_nibble = w_snap_next[15:12];
        endcase
    end

    always_comb begin
        w_seg_next = 8'hFF;
        w_seq_next = 4'hF;
        if (!w_blank_next) begin
            w_seg_next = hex_to_seg(w_nibble);
            // The dp on the top digit marks a special register (PC/MAR/MDR/IR).
            if (w_state_next == DIG3 && w_view_sel_next >= 4'd8)
                w_seg_next[7] = 1'b0;
            w_seq_next = ~(4'b0001 << w_state_next);
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_blank <= 1'b1;
            r_seg   <= 8'hFF;
            r_seq   <= 4'hF;
        end else begin
            r_blank <= w_blank_next;
            r_seg   <= w_seg_next;
            r_seq   <= w_seq_next;
        end
    end

    assign view_sel            = r_view_sel;
    assign led_output          = r_view_sel;
    assign seg_output_single   = r_seg;
    assign seg_output_sequence = r_seq;

endmodule

// File: tb/tb_lc3_debug_display.sv
// -----------------------------------------------------------------------------
// tb_lc3_debug_display
//
// Directed testbench for lc3_debug_display with the default parameters
// (SCAN_DIV = 2, DEBOUNCE_CYCLES = 4, NUM_SRC = 12). Expected values are
// hand-computed seven-segment bytes and cycle counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lc3_debug_display;

    logic        clk_0;
    logic        rst;
    logic        btn;
    logic [15:0] view_value;
    logic [3:0]  view_sel;
    logic [7:0]  seg_output_single;
    logic [3:0]  seg_output_sequence;
    logic [3:0]  led_output;

    int n_checks = 0;
    int n_fails  = 0;

    lc3_debug_display #(
        .SCAN_DIV        (2),
        .DEBOUNCE_CYCLES (4),
        .NUM_SRC         (12)
    ) dut (
        .clk_0               (clk_0),
        .rst                 (rst),
        .btn                 (btn),
        .view_value          (view_value),
        .view_sel            (view_sel),
        .seg_output_single   (seg_output_single),
        .seg_output_sequence (seg_output_sequence),
        .led_output          (led_output)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk_0);
        #1;
    endtask

    // Advance until digit n is enabled, bounded by a cycle budget.
    task automatic wait_digit(input int n);
        logic [3:0] pat;
        bit         found;
        pat   = ~(4'b0001 << n);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (seg_output_sequence == pat) begin
                found = 1'b1;
                break;
            end
        end
        if (!found)
            check("wait_digit_timeout", 32'(found), 32'd1);
    endtask

    // A qualified press: held long enough to step, then released long
    // enough for the debounce counter to clear.
    task automatic press();
        btn = 1'b1;
        repeat (8) cyc();
        btn = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        rst        = 1'b0;
        btn        = 1'b0;
        view_value = 16'h3A0F;

        // ---------------- Reset ----------------
        repeat (10) cyc();
        check("rst_seg",  32'(seg_output_single),   32'hFF);
        check("rst_seq",  32'(seg_output_sequence), 32'hF);
        check("rst_led",  32'(led_output),          32'h0);
        check("rst_vsel", 32'(view_sel),            32'h0);
        rst = 1'b1;

        // ---------------- Scan decode (3A0F) ----------------
        repeat (2) cyc();
        check("dig0_seq", 32'(seg_output_sequence), 32'hE);
        check("dig0_seg", 32'(seg_output_single),   32'h8E);
        repeat (2) cyc();
        check("dig1_seq", 32'(seg_output_sequence), 32'hD);
        check("dig1_seg", 32'(seg_output_single),   32'hC0);
        repeat (2) cyc();
        check("dig2_seq", 32'(seg_output_sequence), 32'hB);
        check("dig2_seg", 32'(seg_output_single),   32'h88);
        repeat (2) cyc();
        check("dig3_seq", 32'(seg_output_sequence), 32'h7);
        check("dig3_seg", 32'(seg_output_single),   32'hB0);
        repeat (2) cyc();
        check("wrap_dig0_seq", 32'(seg_output_sequence), 32'hE);

        // ---------------- Debounce ----------------
        btn = 1'b1;
        repeat (3) cyc();
        btn = 1'b0;
        repeat (10) cyc();
        check("bounce_no_step", 32'(view_sel), 32'h0);

        btn = 1'b1;
        repeat (6) cyc();
        check("press_before_latency", 32'(view_sel), 32'h0);
        cyc();
        check("press_latency_vsel", 32'(view_sel),   32'h1);
        check("press_latency_led",  32'(led_output), 32'h1);
        repeat (13) cyc();
        check("held_single_step", 32'(view_sel), 32'h1);
        btn = 1'b0;
        repeat (10) cyc();
        check("release_no_step", 32'(view_sel), 32'h1);

        // ---------------- Wrap and dp ----------------
        view_value = 16'h3000;
        for (int i = 2; i <= 12; i++) begin
            press();
            check($sformatf("wrap_led_%0d", i), 32'(led_output), 32'(i % 12));
            if (i == 8) begin
                wait_digit(0);
                wait_digit(3);
                check("dp_on_pc", 32'(seg_output_single), 32'h30);
            end
            if (i == 11) begin
                wait_digit(3);
                check("dp_on_ir", 32'(seg_output_single), 32'h30);
            end
        end
        wait_digit(0);
        wait_digit(3);
        check("dp_off_r0", 32'(seg_output_single), 32'hB0);

        // ---------------- Snapshot ----------------
        view_value = 16'h1234;
        wait_digit(3);
        wait_digit(0);
        check("snap_dig0", 32'(seg_output_single), 32'h99);
        wait_digit(2);
        view_value = 16'h5678;
        wait_digit(3);
        check("snap_hold_dig3", 32'(seg_output_single), 32'hF9);
        wait_digit(0);
        check("snap_new_dig0", 32'(seg_output_single), 32'h80);
        wait_digit(1);
        check("snap_new_dig1", 32'(seg_output_single), 32'hF8);
        wait_digit(2);
        check("snap_new_dig2", 32'(seg_output_single), 32'h82);
        wait_digit(3);
        check("snap_new_dig3", 32'(seg_output_single), 32'h92);

        // ---------------- Reset mid-operation ----------------
        for (int i = 0; i < 5; i++) press();
        check("pre_reset_vsel", 32'(view_sel), 32'h5);
        wait_digit(2);
        rst = 1'b0;
        #1;
        check("midrst_seg",  32'(seg_output_single),   32'hFF);
        check("midrst_seq",  32'(seg_output_sequence), 32'hF);
        check("midrst_led",  32'(led_output),          32'h0);
        check("midrst_vsel", 32'(view_sel),            32'h0);
        view_value = 16'h3A0F;
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        check("restart_dig0_seq", 32'(seg_output_sequence), 32'hE);
        check("restart_dig0_seg", 32'(seg_output_single),   32'h8E);
        repeat (2) cyc();
        check("restart_dig1_seq", 32'(seg_output_sequence), 32'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
